// File: rtl/player_move_ctrl_pkg.sv
// rtl/player_move_ctrl_pkg.sv - shared direction codes, screen/grid constants and state encodings
package player_move_ctrl_pkg;

  // Direction codes shared with the collision checker
  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_POS  = 2'd1;  // right / down
  localparam logic [1:0] DIR_NEG  = 2'd2;  // left / up

  // Movement configuration
  localparam logic [2:0] STEP      = 3'd2;
  localparam logic [9:0] X_INIT    = 10'd150;
  localparam logic [9:0] Y_INIT    = 10'd70;
  localparam logic [9:0] X_MAX_POS = 10'd620;
  localparam logic [9:0] Y_MAX_POS = 10'd460;
  localparam logic [5:0] TIMEOUT   = 6'd32;

  // Screen and map grid geometry
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int GRID_X0   = 80;
  localparam int GRID_CELL = 60;
  localparam int GRID_N    = 8;

  // Externally visible sequence state
  typedef enum logic [3:0] {
    IDLE,
    X_CLR,
    X_START,
    X_WAIT,
    X_APPLY,
    Y_CLR,
    Y_START,
    Y_WAIT,
    Y_APPLY,
    FIN
  } state_t;

  // Per-axis stepper state
  typedef enum logic [2:0] {
    AX_IDLE,
    AX_CLR,
    AX_START,
    AX_WAIT,
    AX_APPLY
  } axis_state_t;

  // Frame-level phase of the top sequencer
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_RUN,
    PH_FIN
  } phase_t;

  // Opposing buttons cancel to no movement on that axis
  function automatic logic [1:0] resolve_dir(input logic pos_btn, input logic neg_btn);
    if (pos_btn && !neg_btn) begin
      return DIR_POS;
    end else if (neg_btn && !pos_btn) begin
      return DIR_NEG;
    end
    return DIR_NONE;
  endfunction

endpackage

// File: rtl/player_move_ctrl_axis_stepper.sv
// rtl/player_move_ctrl_axis_stepper.sv - per-axis clear/start/wait/apply loop with step counter and bound check (MOVE_TIMEOUT_EN adds wait watchdog)
module player_move_ctrl_axis_stepper
  import player_move_ctrl_pkg::*;
#(
  parameter logic [9:0] POS_INIT = 10'd0,
  parameter logic [9:0] POS_MAX  = 10'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  dir,
  input  logic        chk_done,
  input  logic        chk_valid,
  output logic [9:0]  pos,
  output axis_state_t ax_state,
  output logic        done,
  output logic        commit
`ifdef MOVE_TIMEOUT_EN
  ,
  output logic        tmo
`endif
);

  axis_state_t state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [9:0]  pos_q, pos_d;
  logic        at_bound;
  logic        skip;
`ifdef MOVE_TIMEOUT_EN
  logic [5:0]  tmo_cnt_q, tmo_cnt_d;
`endif

  // Never step past the screen edge: no wrap below 0 or above POS_MAX
  assign at_bound = ((dir == DIR_NEG) && (pos_q == 10'd0)) ||
                    ((dir == DIR_POS) && (pos_q == POS_MAX));
  assign skip     = (dir == DIR_NONE) || (cnt_q == 3'd0) || at_bound;

  assign pos      = pos_q;
  assign ax_state = state_q;

  // State, step counter and position registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= AX_IDLE;
      cnt_q   <= STEP;
      pos_q   <= POS_INIT;
`ifdef MOVE_TIMEOUT_EN
      tmo_cnt_q <= 6'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
`ifdef MOVE_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  // Next-state logic: one checked pixel per CLR..APPLY loop, done pulses when the axis ends
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    done    = 1'b0;
    commit  = 1'b0;
`ifdef MOVE_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    tmo       = 1'b0;
`endif
    case (state_q)
      AX_IDLE: begin
        if (start) begin
          cnt_d   = STEP;
          state_d = AX_CLR;
        end
      end
      AX_CLR: begin
        if (skip) begin
          done    = 1'b1;
          state_d = AX_IDLE;
        end else begin
          state_d = AX_START;
        end
      end
      AX_START: begin
        state_d = AX_WAIT;
`ifdef MOVE_TIMEOUT_EN
        tmo_cnt_d = 6'd0;
`endif
      end
      AX_WAIT: begin
        if (chk_done) begin
          state_d = AX_APPLY;
        end
`ifdef MOVE_TIMEOUT_EN
        else if (tmo_cnt_q == TIMEOUT - 6'd1) begin
          // A silent checker counts as a blocked pixel
          tmo     = 1'b1;
          done    = 1'b1;
          cnt_d   = STEP;
          state_d = AX_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 6'd1;
        end
`endif
      end
      AX_APPLY: begin
        if (chk_valid) begin
          if (dir == DIR_POS) begin
            pos_d = pos_q + 10'd1;
          end else if (dir == DIR_NEG) begin
            pos_d = pos_q - 10'd1;
          end
          cnt_d   = cnt_q - 3'd1;
          commit  = 1'b1;
          state_d = AX_CLR;
        end else begin
          // Blocked: stop this axis so the other one can still slide along the wall
          cnt_d   = STEP;
          done    = 1'b1;
          state_d = AX_IDLE;
        end
      end
      default: state_d = AX_IDLE;
    endcase
  end

endmodule

// File: rtl/player_move_ctrl.sv
// rtl/player_move_ctrl.sv - per-frame player movement sequencer driving the collision checker (optional MOVE_TIMEOUT_EN watchdog)
module player_move_ctrl
  import player_move_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       chk_done,
  input  logic       chk_valid,
  output logic       chk_rst_n,
  output logic       chk_start,
  output logic [1:0] chk_l_r,
  output logic [1:0] chk_u_d,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       busy,
  output logic       moved,
  output logic       timeout_err
);

  phase_t      phase_q, phase_d;
  logic [1:0]  x_dir_q, x_dir_d;
  logic [1:0]  y_dir_q, y_dir_d;
  logic        moved_flag_q, moved_flag_d;
  logic        moved_q, moved_d;
  logic        x_start;
  logic        x_done, y_done;
  logic        x_commit, y_commit;
  axis_state_t x_state, y_state;
  state_t      state;
`ifdef MOVE_TIMEOUT_EN
  logic        x_tmo, y_tmo;
  logic        timeout_err_q, timeout_err_d;
`endif

  // X axis runs first; its completion starts the Y axis
  player_move_ctrl_axis_stepper #(
    .POS_INIT (X_INIT),
    .POS_MAX  (X_MAX_POS)
  ) u_x_stepper (
    .clk       (clk),
    .rst       (rst),
    .start     (x_start),
    .dir       (x_dir_q),
    .chk_done  (chk_done),
    .chk_valid (chk_valid),
    .pos       (x_pos),
    .ax_state  (x_state),
    .done      (x_done),
    .commit    (x_commit)
`ifdef MOVE_TIMEOUT_EN
    ,
    .tmo       (x_tmo)
`endif
  );

  player_move_ctrl_axis_stepper #(
    .POS_INIT (Y_INIT),
    .POS_MAX  (Y_MAX_POS)
  ) u_y_stepper (
    .clk       (clk),
    .rst       (rst),
    .start     (x_done),
    .dir       (y_dir_q),
    .chk_done  (chk_done),
    .chk_valid (chk_valid),
    .pos       (y_pos),
    .ax_state  (y_state),
    .done      (y_done),
    .commit    (y_commit)
`ifdef MOVE_TIMEOUT_EN
    ,
    .tmo       (y_tmo)
`endif
  );

  // Frame phase, latched directions and move reporting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q      <= PH_IDLE;
      x_dir_q      <= DIR_NONE;
      y_dir_q      <= DIR_NONE;
      moved_flag_q <= 1'b0;
      moved_q      <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      x_dir_q      <= x_dir_d;
      y_dir_q      <= y_dir_d;
      moved_flag_q <= moved_flag_d;
      moved_q      <= moved_d;
    end
  end

  // Accept a frame only when idle; ticks arriving mid-sequence are dropped
  always_comb begin
    phase_d      = phase_q;
    x_dir_d      = x_dir_q;
    y_dir_d      = y_dir_q;
    moved_flag_d = moved_flag_q | x_commit | y_commit;
    moved_d      = 1'b0;
    x_start      = 1'b0;
    case (phase_q)
      PH_IDLE: begin
        if (frame_tick) begin
          x_dir_d = resolve_dir(btn_right, btn_left);
          y_dir_d = resolve_dir(btn_down, btn_up);
          x_start = 1'b1;
          phase_d = PH_RUN;
        end
      end
      PH_RUN: begin
        if (y_done) begin
          phase_d = PH_FIN;
        end
      end
      PH_FIN: begin
        moved_d      = moved_flag_q;
        moved_flag_d = 1'b0;
        phase_d      = PH_IDLE;
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  // Combined sequence state as seen from outside
  always_comb begin
    state = IDLE;
    if (phase_q == PH_FIN) begin
      state = FIN;
    end else if (phase_q == PH_RUN) begin
      case (x_state)
        AX_CLR:   state = X_CLR;
        AX_START: state = X_START;
        AX_WAIT:  state = X_WAIT;
        AX_APPLY: state = X_APPLY;
        default: begin
          case (y_state)
            AX_CLR:   state = Y_CLR;
            AX_START: state = Y_START;
            AX_WAIT:  state = Y_WAIT;
            AX_APPLY: state = Y_APPLY;
            default:  state = IDLE;
          endcase
        end
      endcase
    end
  end

  assign busy      = (phase_q != PH_IDLE);
  assign moved     = moved_q;
  assign chk_rst_n = ~rst & ~((state == X_CLR) || (state == Y_CLR));
  assign chk_start = (x_state == AX_START) || (y_state == AX_START);
  assign chk_l_r   = ((x_state == AX_CLR) || (x_state == AX_START) || (x_state == AX_WAIT)) ? x_dir_q : DIR_NONE;
  assign chk_u_d   = ((y_state == AX_CLR) || (y_state == AX_START) || (y_state == AX_WAIT)) ? y_dir_q : DIR_NONE;

`ifdef MOVE_TIMEOUT_EN
  assign timeout_err_d = timeout_err_q | x_tmo | y_tmo;

  // Sticky watchdog flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_player_move_ctrl.sv
// tb/tb_player_move_ctrl.sv - self-checking bench for player_move_ctrl with reactive checker model
`timescale 1ns/1ps
module tb_player_move_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       chk_done = 1'b0;
  logic       chk_valid = 1'b0;
  logic       chk_rst_n;
  logic       chk_start;
  logic [1:0] chk_l_r;
  logic [1:0] chk_u_d;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic       busy;
  logic       moved;
  logic       timeout_err;

  always #5 clk = ~clk;

  player_move_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .chk_done    (chk_done),
    .chk_valid   (chk_valid),
    .chk_rst_n   (chk_rst_n),
    .chk_start   (chk_start),
    .chk_l_r     (chk_l_r),
    .chk_u_d     (chk_u_d),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .busy        (busy),
    .moved       (moved),
    .timeout_err (timeout_err)
  );

  typedef struct {
    int x;
    int y;
    int checks;
    int moved;
    int first_lr;
    int last_ud;
    int busy;
  } exp_t;

  typedef struct {
    logic       l;
    logic       r;
    logic       u;
    logic       d;
    logic [7:0] mask;
    exp_t       e;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[7];

  int n_checks = 0;
  int n_pass = 0;

  int         lat = 1;
  logic       never_done = 1'b0;
  logic [7:0] valid_mask = 8'hFF;
  int         frame_base = 0;
  int         countdown = 0;
  logic       pending_valid = 1'b0;
  int         total_starts = 0;
  int         total_moved = 0;
  int         total_busy = 0;
  int         lr_log[256];
  int         ud_log[256];

  // Checker model and activity monitor, both evaluated away from the active edge
  always @(negedge clk) begin
    int idx;
    if (busy) total_busy = total_busy + 1;
    if (moved) total_moved = total_moved + 1;
    if (!chk_rst_n) begin
      chk_done  = 1'b0;
      chk_valid = 1'b0;
      countdown = 0;
    end else if (chk_start) begin
      lr_log[total_starts % 256] = int'(chk_l_r);
      ud_log[total_starts % 256] = int'(chk_u_d);
      idx = (total_starts - frame_base) % 8;
      pending_valid = valid_mask[idx];
      total_starts = total_starts + 1;
      countdown = never_done ? 0 : lat;
    end else if (countdown > 0) begin
      countdown = countdown - 1;
      if (countdown == 0) begin
        chk_done  = 1'b1;
        chk_valid = pending_valid;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic vec_t mkv(input logic l, input logic r, input logic u, input logic d,
                               input logic [7:0] m, input int x, input int y, input int c,
                               input int mv, input int flr, input int lud, input int bz);
    vec_t v;
    v.l = l; v.r = r; v.u = u; v.d = d; v.mask = m;
    v.e.x = x; v.e.y = y; v.e.checks = c; v.e.moved = mv;
    v.e.first_lr = flr; v.e.last_ud = lud; v.e.busy = bz;
    return v;
  endfunction

  // One frame: pulse frame_tick, wait (bounded) for the sequence to end, report activity
  task automatic run_frame(input logic l, input logic r, input logic u, input logic d,
                           input logic [7:0] mask, output int starts, output int mv,
                           output int bz, output int flr, output int lud);
    int sb, mb, bb, guard;
    btn_left = l; btn_right = r; btn_up = u; btn_down = d;
    valid_mask = mask;
    frame_base = total_starts;
    sb = total_starts; mb = total_moved; bb = total_busy;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    guard = 0;
    while (busy && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) begin
      n_checks++;
      $display("FAIL frame_end: busy still %0d after %0d cycles, required 0", busy, guard);
    end
    repeat (2) @(negedge clk);
    #1;
    starts = total_starts - sb;
    mv  = total_moved - mb;
    bz  = total_busy - bb;
    flr = (starts > 0) ? lr_log[sb % 256] : 0;
    lud = (starts > 0) ? ud_log[(total_starts - 1) % 256] : 0;
  endtask

  initial begin
    int st, mv, bz, flr, lud, sb, mb, bb, guard;
    exp_t e;

    //            l     r     u     d     mask   x    y   chk mv lr ud busy
    vecs[0] = mkv(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 152, 70, 2, 1, 1, 0, 0);
    vecs[1] = mkv(1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 153, 70, 2, 1, 1, 0, 0);
    vecs[2] = mkv(1'b1, 1'b0, 1'b1, 1'b0, 8'h06, 153, 68, 3, 1, 2, 2, 0);
    vecs[3] = mkv(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 153, 68, 0, 0, 0, 0, 3);
    vecs[4] = mkv(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 153, 68, 1, 0, 2, 0, 0);
    vecs[5] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 153, 70, 2, 1, 0, 1, 0);
    vecs[6] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 153, 70, 0, 0, 0, 0, 3);

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst chk_rst_n", int'(chk_rst_n), 0);
    check("rst x_pos", int'(x_pos), 150);
    check("rst y_pos", int'(y_pos), 70);
    check("rst busy", int'(busy), 0);
    check("rst moved", int'(moved), 0);
    check("rst chk_start", int'(chk_start), 0);
    check("rst chk_l_r", int'(chk_l_r), 0);
    check("rst chk_u_d", int'(chk_u_d), 0);
    check("rst timeout_err", int'(timeout_err), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post-rst chk_rst_n", int'(chk_rst_n), 1);
    check("post-rst busy", int'(busy), 0);

    // Table-driven frames through the scoreboard
    for (int i = 0; i < 7; i++) begin
      sb_q.push_back(vecs[i].e);
      run_frame(vecs[i].l, vecs[i].r, vecs[i].u, vecs[i].d, vecs[i].mask, st, mv, bz, flr, lud);
      e = sb_q.pop_front();
      check($sformatf("v%0d x_pos", i), int'(x_pos), e.x);
      check($sformatf("v%0d y_pos", i), int'(y_pos), e.y);
      check($sformatf("v%0d checks", i), st, e.checks);
      check($sformatf("v%0d moved", i), mv, e.moved);
      check($sformatf("v%0d first_lr", i), flr, e.first_lr);
      check($sformatf("v%0d last_ud", i), lud, e.last_ud);
      if (e.busy != 0) check($sformatf("v%0d busy_cycles", i), bz, e.busy);
    end

    // Second frame_tick while busy is dropped, not queued
    lat = 4;
    btn_left = 1'b0; btn_right = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
    valid_mask = 8'hFF;
    frame_base = total_starts;
    sb = total_starts; mb = total_moved;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    check("drop busy_before_tick2", int'(busy), 1);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    guard = 0;
    while (busy && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check("drop frame_end_in_budget", int'(guard < 400), 1);
    bb = total_busy;
    repeat (4) @(negedge clk);
    #1;
    check("drop no_requeue", total_busy - bb, 0);
    check("drop x_pos", int'(x_pos), 155);
    check("drop checks", total_starts - sb, 2);
    check("drop moved", total_moved - mb, 1);
    lat = 1;

    // Walk to the left edge, then confirm no check and no wrap at x_pos = 0
    for (int f = 0; f < 100 && x_pos != 10'd0; f++) begin
      run_frame(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, st, mv, bz, flr, lud);
    end
    check("edge reached x_pos", int'(x_pos), 0);
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, st, mv, bz, flr, lud);
    check("edge x_pos", int'(x_pos), 0);
    check("edge checks", st, 0);
    check("edge moved", mv, 0);
    check("edge y_pos", int'(y_pos), 70);

`ifdef MOVE_TIMEOUT_EN
    // Silent checker: abort after the watchdog limit, sticky error
    never_done = 1'b1;
    run_frame(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, st, mv, bz, flr, lud);
    check("tmo timeout_err", int'(timeout_err), 1);
    check("tmo checks", st, 1);
    check("tmo x_pos", int'(x_pos), 0);
    check("tmo moved", mv, 0);
    check("tmo busy_cycles", bz, 36);
    never_done = 1'b0;
`endif

    // Reset in the middle of X_WAIT: no completion of the pending step
    never_done = 1'b1;
    btn_left = 1'b0; btn_right = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
    frame_base = total_starts;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("midwait busy", int'(busy), 1);
    check("midwait chk_rst_n", int'(chk_rst_n), 1);
    #1;
    rst = 1'b1;
    #1;
    check("midrst x_pos", int'(x_pos), 150);
    check("midrst y_pos", int'(y_pos), 70);
    check("midrst chk_rst_n", int'(chk_rst_n), 0);
    check("midrst busy", int'(busy), 0);
    check("midrst timeout_err", int'(timeout_err), 0);
    @(negedge clk);
    rst = 1'b0;
    never_done = 1'b0;
    btn_right = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("after-rst busy", int'(busy), 0);
    check("after-rst chk_rst_n", int'(chk_rst_n), 1);
    check("after-rst x_pos", int'(x_pos), 150);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
